irq_service_sequencer: RTL and testbench
========================================

Name: irq_service_sequencer

Overview:
- Downstream consumer of the 27-channel combinational interrupt priority encoder.
- Inputs per cycle: 3 group-hit flags and a 4-bit in-group channel index from the encoder.
- Debounces that snapshot, raises one vectored interrupt to the CPU, runs the ack/end-of-interrupt handshake, then pulses a one-hot clear back to the upstream request latch.
- Keeps saturating service and timeout counters.

Parameters:
SETTLE_CYC, 2, consecutive stable cycles required before the IRQ is raised (legal range 1..15)
ACK_TIMEOUT, 255, cycles cpu_irq may stay high without cpu_ack before it is dropped (legal range 1..65535)
CNT_W, 8, width of the statistics counters

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
grp_hit  in  3  encoder group flags, active high; bit0 = highest-priority group (channels 0-8), bit1 = 9-17, bit2 = 18-26
chan_idx  in  4  encoder in-group channel index; only 0..8 are legal
cpu_irq  out  1  interrupt request to CPU, level
cpu_vector  out  5  channel number 0..26; valid while cpu_irq or busy is high
cpu_ack  in  1  CPU accepts the interrupt
cpu_eoi  in  1  CPU end-of-interrupt
clr_onehot  out  27  one-cycle clear pulse to the request latch, bit = serviced channel
busy  out  1  high in ASSERT and SERVICE
bad_idx  out  1  one-cycle pulse when a settled snapshot has chan_idx > 8
serviced_cnt  out  CNT_W  saturating count of completed services
timeout_cnt  out  CNT_W  saturating count of ack timeouts

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0.
  - State IDLE; snapshot, settle counter and timeout counter cleared.
  - Takes effect immediately, in any state, including mid-handshake. No clear pulse is issued for an interrupted service.
- Snapshot: {grp_hit, chan_idx}. Group g = index of the lowest set bit of grp_hit. Vector = 9*g + chan_idx, computed in 5 bits.
- States: IDLE, SETTLE, ASSERT, SERVICE, CLEAR, GAP.
- IDLE:
  - If grp_hit != 0 at an edge: capture snapshot, settle counter = 0, go to SETTLE.
  - cpu_ack and cpu_eoi are ignored.
- SETTLE, at each edge:
  - If grp_hit == 0: go to IDLE.
  - Else if live inputs differ from the snapshot: recapture, counter = 0.
  - Else if counter == SETTLE_CYC-1:
    - chan_idx legal: latch the vector, go to ASSERT.
    - chan_idx illegal: pulse bad_idx, go to GAP.
  - Else: counter++.
  - Latency: cpu_irq rises exactly SETTLE_CYC edges after the first sampling edge when inputs are stable.
- ASSERT:
  - cpu_irq=1, busy=1, cpu_vector held constant.
  - cpu_ack=1: go to SERVICE; cpu_irq drops on that edge. A cpu_eoi in the same cycle is ignored.
  - After ACK_TIMEOUT cycles in ASSERT with no ack:
    - drop cpu_irq
    - timeout_cnt++ (saturating)
    - go to GAP with no clear pulse.
  - A same-cycle ack on the timeout cycle wins: SERVICE, no timeout counted.
- SERVICE:
  - busy=1, cpu_irq=0, vector held.
  - Waits indefinitely for cpu_eoi, then goes to CLEAR.
  - Further cpu_ack is ignored.
- CLEAR:
  - Exactly one cycle with clr_onehot = 1 << vector.
  - serviced_cnt++ (saturating at 2^CNT_W-1).
  - Next state GAP.
- GAP:
  - One cycle; inputs ignored so the upstream latch and encoder can update.
  - Next state IDLE.
- Invariants:
  - clr_onehot is all-zero outside CLEAR and never has more than one bit set.
  - cpu_vector is 0 in IDLE, SETTLE and GAP.
  - Inputs are not re-sampled in ASSERT or SERVICE; priority changes there are ignored until the next IDLE.
- Arithmetic:
  - Counters saturate and never wrap.
  - The timeout counter is 16 bits and resets on ASSERT entry.

Test Plan:
- Stable grp_hit=3'b010, chan_idx=4, SETTLE_CYC=2 -> cpu_irq high after 2nd edge, cpu_vector=13; ack then eoi -> clr_onehot bit13 for 1 cycle, serviced_cnt=1, back in IDLE after GAP.
- chan_idx toggles 3->5 during SETTLE with grp_hit=3'b001 -> counter restarts; IRQ raised with vector=5 only after 2 stable cycles on 5.
- grp_hit=3'b100, chan_idx=11 held -> bad_idx single pulse, no cpu_irq, no clear; re-evaluates after GAP.
- No ack, ACK_TIMEOUT=4 -> cpu_irq high exactly 4 cycles, then low, timeout_cnt=1, clr_onehot stays 0; ack on 4th cycle -> SERVICE, timeout_cnt unchanged.
- rst_n pulsed low in SERVICE -> cpu_irq, busy, cpu_vector, counters 0 immediately; no clr pulse after release.
- CNT_W=2, four full services -> serviced_cnt reads 3 after the 3rd and 4th; cpu_eoi asserted in IDLE has no effect.

Source files
------------

// File: rtl/irq_service_sequencer.sv
// Debounces the priority-encoder snapshot, raises one vectored IRQ, runs the
// ack/EOI handshake, then pulses a one-hot clear back to the request latch.
module irq_service_sequencer #(
   parameter int SETTLE_CYC  = 2,
   parameter int ACK_TIMEOUT = 255,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       grp_hit,
   input  logic [3:0]       chan_idx,
   output logic             cpu_irq,
   output logic [4:0]       cpu_vector,
   input  logic             cpu_ack,
   input  logic             cpu_eoi,
   output logic [26:0]      clr_onehot,
   output logic             busy,
   output logic             bad_idx,
   output logic [CNT_W-1:0] serviced_cnt,
   output logic [CNT_W-1:0] timeout_cnt,
   output logic [2:0]       state_dbg
);

   // CPU handshake: cpu_irq is a level held until the first cycle cpu_ack is
   // seen high (transfer), after which cpu_eoi high for one cycle completes it.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_ASSERT  = 3'd2,
      ST_SERVICE = 3'd3,
      ST_CLEAR   = 3'd4,
      ST_GAP     = 3'd5
   } state_t;

   localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYC - 1);
   localparam logic [15:0] TO_LAST     = 16'(ACK_TIMEOUT - 1);

   state_t      state;
   logic [6:0]  snap;
   logic [3:0]  settle_cnt;
   logic [15:0] to_cnt;
   logic [4:0]  live_vec;

   assign state_dbg = state;

   // Lowest set group bit wins; vector = 9*group + in-group index.
   always_comb begin
      live_vec = '0;
      if (grp_hit[0])      live_vec = {1'b0, chan_idx};
      else if (grp_hit[1]) live_vec = 5'd9 + {1'b0, chan_idx};
      else if (grp_hit[2]) live_vec = 5'd18 + {1'b0, chan_idx};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         snap         <= '0;
         settle_cnt   <= '0;
         to_cnt       <= '0;
         cpu_irq      <= 1'b0;
         cpu_vector   <= '0;
         clr_onehot   <= '0;
         busy         <= 1'b0;
         bad_idx      <= 1'b0;
         serviced_cnt <= '0;
         timeout_cnt  <= '0;
      end else begin
         bad_idx    <= 1'b0;
         clr_onehot <= '0;
         case (state)
            ST_IDLE: begin
               if (grp_hit != 3'b000) begin
                  snap       <= {grp_hit, chan_idx};
                  settle_cnt <= '0;
                  state      <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (grp_hit == 3'b000) begin
                  state <= ST_IDLE;
               end else if ({grp_hit, chan_idx} != snap) begin
                  snap       <= {grp_hit, chan_idx};
                  settle_cnt <= '0;
               end else if (settle_cnt == SETTLE_LAST) begin
                  if (chan_idx <= 4'd8) begin
                     cpu_vector <= live_vec;
                     cpu_irq    <= 1'b1;
                     busy       <= 1'b1;
                     to_cnt     <= '0;
                     state      <= ST_ASSERT;
                  end else begin
                     bad_idx <= 1'b1;
                     state   <= ST_GAP;
                  end
               end else begin
                  settle_cnt <= settle_cnt + 4'd1;
               end
            end
            ST_ASSERT: begin
               // An ack on the final timeout cycle still wins.
               if (cpu_ack) begin
                  cpu_irq <= 1'b0;
                  state   <= ST_SERVICE;
               end else if (to_cnt == TO_LAST) begin
                  cpu_irq    <= 1'b0;
                  busy       <= 1'b0;
                  cpu_vector <= '0;
                  if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + CNT_W'(1);
                  state      <= ST_GAP;
               end else begin
                  to_cnt <= to_cnt + 16'd1;
               end
            end
            ST_SERVICE: begin
               if (cpu_eoi) begin
                  busy       <= 1'b0;
                  clr_onehot <= 27'd1 << cpu_vector;
                  if (serviced_cnt != '1) serviced_cnt <= serviced_cnt + CNT_W'(1);
                  state      <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               cpu_vector <= '0;
               state      <= ST_GAP;
            end
            ST_GAP:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_service_sequencer.sv
// Scenario bench for irq_service_sequencer: expected vectors are queued when a
// request is driven and popped when cpu_irq rises.
module tb_irq_service_sequencer;

   localparam int CNT_W = 2;
   localparam logic [2:0] S_IDLE = 3'd0, S_SETTLE = 3'd1, S_SERVICE = 3'd3, S_GAP = 3'd5;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [2:0]       grp_hit;
   logic [3:0]       chan_idx;
   logic             cpu_irq;
   logic [4:0]       cpu_vector;
   logic             cpu_ack;
   logic             cpu_eoi;
   logic [26:0]      clr_onehot;
   logic             busy;
   logic             bad_idx;
   logic [CNT_W-1:0] serviced_cnt;
   logic [CNT_W-1:0] timeout_cnt;
   logic [2:0]       state_dbg;

   int tests_run = 0;
   int tests_failed = 0;
   logic [4:0] exp_q[$];
   logic [4:0] exp_vec;
   int exp_serv = 0;
   int exp_to = 0;

   irq_service_sequencer #(.SETTLE_CYC(2), .ACK_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .grp_hit(grp_hit), .chan_idx(chan_idx),
      .cpu_irq(cpu_irq), .cpu_vector(cpu_vector), .cpu_ack(cpu_ack), .cpu_eoi(cpu_eoi),
      .clr_onehot(clr_onehot), .busy(busy), .bad_idx(bad_idx),
      .serviced_cnt(serviced_cnt), .timeout_cnt(timeout_cnt), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ack_eoi();
      cpu_ack = 1'b1;
      tick();
      cpu_ack = 1'b0;
      cpu_eoi = 1'b1;
      tick();
      cpu_eoi = 1'b0;
   endtask

   function automatic logic [4:0] model_vec(input logic [2:0] g, input logic [3:0] c);
      if (g[0]) return 5'(c);
      if (g[1]) return 5'(9 + int'(c));
      return 5'(18 + int'(c));
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; grp_hit = '0; chan_idx = '0; cpu_ack = 1'b0; cpu_eoi = 1'b0;
      #3;
      tests_run++;
      if ({cpu_irq, cpu_vector, clr_onehot, busy, bad_idx, serviced_cnt, timeout_cnt, state_dbg} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: irq=%0b vec=%0d clr=%h busy=%0b bad=%0b srv=%0d to=%0d st=%0d, required all 0",
                  cpu_irq, cpu_vector, clr_onehot, busy, bad_idx, serviced_cnt, timeout_cnt, state_dbg);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      grp_hit = 3'b010; chan_idx = 4'd4;
      exp_q.push_back(model_vec(3'b010, 4'd4));
      tick(); tick();
      tests_run++;
      if (cpu_irq !== 1'b0) begin
         tests_failed++; $display("FAIL basic_early_irq: got %0b required 0", cpu_irq);
      end
      tick();
      exp_vec = exp_q.pop_front();
      tests_run++;
      if (cpu_irq !== 1'b1 || busy !== 1'b1 || cpu_vector !== exp_vec) begin
         tests_failed++;
         $display("FAIL basic_irq: irq=%0b busy=%0b vec=%0d required 1/1/%0d", cpu_irq, busy, cpu_vector, exp_vec);
      end
      cpu_ack = 1'b1; cpu_eoi = 1'b1;
      tick();
      cpu_ack = 1'b0; cpu_eoi = 1'b0;
      tests_run++;
      if (cpu_irq !== 1'b0 || busy !== 1'b1 || state_dbg !== S_SERVICE || clr_onehot !== '0) begin
         tests_failed++;
         $display("FAIL basic_service: irq=%0b busy=%0b st=%0d clr=%h required 0/1/%0d/0", cpu_irq, busy, state_dbg, clr_onehot, S_SERVICE);
      end
      cpu_eoi = 1'b1;
      tick();
      cpu_eoi = 1'b0;
      grp_hit = '0;
      exp_serv++;
      tests_run++;
      if (clr_onehot !== (27'd1 << exp_vec) || serviced_cnt !== CNT_W'(exp_serv)) begin
         tests_failed++;
         $display("FAIL basic_clear: clr=%h srv=%0d required %h/%0d", clr_onehot, serviced_cnt, 27'd1 << exp_vec, exp_serv);
      end
      tick();
      tests_run++;
      if (clr_onehot !== '0 || cpu_vector !== 5'd0 || state_dbg !== S_GAP) begin
         tests_failed++; $display("FAIL basic_gap: clr=%h vec=%0d st=%0d required 0/0/%0d", clr_onehot, cpu_vector, state_dbg, S_GAP);
      end
      tick();
      tests_run++;
      if (state_dbg !== S_IDLE || busy !== 1'b0) begin
         tests_failed++; $display("FAIL basic_idle: st=%0d busy=%0b required %0d/0", state_dbg, busy, S_IDLE);
      end
   endtask

   task automatic test_retrigger();
      grp_hit = 3'b001; chan_idx = 4'd3;
      tick();
      chan_idx = 4'd5;
      exp_q.push_back(model_vec(3'b001, 4'd5));
      tick(); tick();
      tests_run++;
      if (cpu_irq !== 1'b0) begin
         tests_failed++; $display("FAIL retrigger_early: irq=%0b required 0", cpu_irq);
      end
      tick();
      exp_vec = exp_q.pop_front();
      tests_run++;
      if (cpu_irq !== 1'b1 || cpu_vector !== exp_vec) begin
         tests_failed++; $display("FAIL retrigger_irq: irq=%0b vec=%0d required 1/%0d", cpu_irq, cpu_vector, exp_vec);
      end
      ack_eoi();
      grp_hit = '0;
      exp_serv++;
      tests_run++;
      if (clr_onehot !== (27'd1 << exp_vec) || serviced_cnt !== CNT_W'(exp_serv)) begin
         tests_failed++;
         $display("FAIL retrigger_clear: clr=%h srv=%0d required %h/%0d", clr_onehot, serviced_cnt, 27'd1 << exp_vec, exp_serv);
      end
      tick(); tick();
   endtask

   task automatic test_bad_idx();
      int pulses = 0;
      int irqs = 0;
      int clrs = 0;
      grp_hit = 3'b100; chan_idx = 4'd11;
      for (int i = 0; i < 4; i++) begin
         tick();
         pulses += int'(bad_idx); irqs += int'(cpu_irq); clrs += int'(|clr_onehot);
      end
      tests_run++;
      if (pulses != 1 || irqs != 0 || clrs != 0) begin
         tests_failed++; $display("FAIL bad_idx_pulse: pulses=%0d irqs=%0d clrs=%0d required 1/0/0", pulses, irqs, clrs);
      end
      tick();
      tests_run++;
      if (state_dbg !== S_SETTLE) begin
         tests_failed++; $display("FAIL bad_idx_reeval: st=%0d required %0d", state_dbg, S_SETTLE);
      end
      grp_hit = '0;
      tick();
   endtask

   task automatic test_timeout();
      int high = 1;
      int clrs = 0;
      grp_hit = 3'b010; chan_idx = 4'd0;
      exp_q.push_back(model_vec(3'b010, 4'd0));
      tick(); tick(); tick();
      grp_hit = '0;
      exp_vec = exp_q.pop_front();
      tests_run++;
      if (cpu_irq !== 1'b1 || cpu_vector !== exp_vec) begin
         tests_failed++; $display("FAIL timeout_irq: irq=%0b vec=%0d required 1/%0d", cpu_irq, cpu_vector, exp_vec);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         clrs += int'(|clr_onehot);
         if (cpu_irq) high++;
         else break;
      end
      exp_to++;
      tests_run++;
      if (high != 4 || timeout_cnt !== CNT_W'(exp_to) || clrs != 0 || state_dbg !== S_GAP) begin
         tests_failed++;
         $display("FAIL timeout_drop: high=%0d to=%0d clrs=%0d st=%0d required 4/%0d/0/%0d", high, timeout_cnt, clrs, state_dbg, exp_to, S_GAP);
      end
      tick();
      grp_hit = 3'b010; chan_idx = 4'd1;
      exp_q.push_back(model_vec(3'b010, 4'd1));
      tick(); tick(); tick();
      grp_hit = '0;
      tick(); tick(); tick();
      cpu_ack = 1'b1;
      tick();
      cpu_ack = 1'b0;
      tests_run++;
      if (state_dbg !== S_SERVICE || timeout_cnt !== CNT_W'(exp_to) || cpu_irq !== 1'b0) begin
         tests_failed++;
         $display("FAIL timeout_late_ack: st=%0d to=%0d irq=%0b required %0d/%0d/0", state_dbg, timeout_cnt, cpu_irq, S_SERVICE, exp_to);
      end
      exp_vec = exp_q.pop_front();
      cpu_eoi = 1'b1;
      tick();
      cpu_eoi = 1'b0;
      exp_serv++;
      tests_run++;
      if (clr_onehot !== (27'd1 << exp_vec) || serviced_cnt !== CNT_W'(exp_serv)) begin
         tests_failed++;
         $display("FAIL timeout_late_clear: clr=%h srv=%0d required %h/%0d", clr_onehot, serviced_cnt, 27'd1 << exp_vec, exp_serv);
      end
      tick(); tick();
   endtask

   task automatic test_reset_mid();
      int clrs = 0;
      grp_hit = 3'b001; chan_idx = 4'd7;
      tick(); tick(); tick();
      cpu_ack = 1'b1;
      tick();
      cpu_ack = 1'b0;
      grp_hit = '0;
      #2;
      rst_n = 1'b0;
      #1;
      exp_serv = 0; exp_to = 0;
      tests_run++;
      if ({cpu_irq, busy, cpu_vector, serviced_cnt, timeout_cnt, state_dbg} !== '0) begin
         tests_failed++;
         $display("FAIL reset_mid: irq=%0b busy=%0b vec=%0d srv=%0d to=%0d st=%0d required all 0",
                  cpu_irq, busy, cpu_vector, serviced_cnt, timeout_cnt, state_dbg);
      end
      tick();
      rst_n = 1'b1;
      cpu_eoi = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         clrs += int'(|clr_onehot);
      end
      cpu_eoi = 1'b0;
      tests_run++;
      if (clrs != 0 || state_dbg !== S_IDLE) begin
         tests_failed++; $display("FAIL reset_mid_noclr: clrs=%0d st=%0d required 0/%0d", clrs, state_dbg, S_IDLE);
      end
   endtask

   task automatic test_saturate();
      logic [2:0] g;
      logic [3:0] c;
      for (int n = 0; n < 4; n++) begin
         g = 3'($urandom_range(1, 7));
         c = 4'($urandom_range(0, 8));
         grp_hit = g; chan_idx = c;
         exp_q.push_back(model_vec(g, c));
         tick(); tick(); tick();
         grp_hit = '0;
         exp_vec = exp_q.pop_front();
         tests_run++;
         if (cpu_irq !== 1'b1 || cpu_vector !== exp_vec) begin
            tests_failed++; $display("FAIL sat_irq_%0d: irq=%0b vec=%0d required 1/%0d", n, cpu_irq, cpu_vector, exp_vec);
         end
         ack_eoi();
         exp_serv = (exp_serv == 3) ? 3 : exp_serv + 1;
         tests_run++;
         if (clr_onehot !== (27'd1 << exp_vec) || serviced_cnt !== CNT_W'(exp_serv)) begin
            tests_failed++;
            $display("FAIL sat_clear_%0d: clr=%h srv=%0d required %h/%0d", n, clr_onehot, serviced_cnt, 27'd1 << exp_vec, exp_serv);
         end
         tick(); tick();
      end
      cpu_eoi = 1'b1;
      tick(); tick(); tick();
      cpu_eoi = 1'b0;
      tests_run++;
      if (state_dbg !== S_IDLE || serviced_cnt !== CNT_W'(exp_serv) || clr_onehot !== '0) begin
         tests_failed++;
         $display("FAIL idle_eoi: st=%0d srv=%0d clr=%h required %0d/%0d/0", state_dbg, serviced_cnt, clr_onehot, S_IDLE, exp_serv);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_retrigger();
      test_bad_idx();
      test_timeout();
      test_reset_mid();
      test_saturate();
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++; $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
